// File: rtl/reg_pkg.sv
// Shared definitions for the skid-buffered pipeline register.
// State encoding and parameter limits used by stage and top.
package reg_pkg;

  localparam int REG_STAGES_MAX = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_t;

  // Narrowest count able to hold 0..2*stages.
  function automatic int min_count_width(
    input int stages
  );
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/reg_skid_stage.sv
// One skid stage: main + skid register and a registered ready.
// Ready is !skid_valid so the upstream never sees a comb path.
module reg_skid_stage
  import reg_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  stage_state_t          state;
  logic                  m_valid;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] m_data;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  in_fire;
  logic                  out_fire;

  assign in_fire   = in_valid & ready_q;
  assign out_fire  = m_valid & out_ready;
  assign in_ready  = ready_q;
  assign out_valid = m_valid;
  assign out_data  = m_data;

  // Stage FSM; valids and ready are kept registered alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_EMPTY;
      m_valid <= 1'b0;
      ready_q <= 1'b1;
      m_data  <= '0;
      s_data  <= '0;
    end else if (flush) begin
      state   <= ST_EMPTY;
      m_valid <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            m_data  <= in_data;
            m_valid <= 1'b1;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          unique case ({in_fire, out_fire})
            2'b11: begin
              m_data <= in_data;
            end
            2'b10: begin
              s_data  <= in_data;
              ready_q <= 1'b0;
              state   <= ST_FULL;
            end
            2'b01: begin
              m_valid <= 1'b0;
              state   <= ST_EMPTY;
            end
            default: begin
            end
          endcase
        end
        ST_FULL: begin
          if (out_fire) begin
            m_data  <= s_data;
            ready_q <= 1'b1;
            state   <= ST_BUSY;
          end
        end
        default: begin
          state   <= ST_EMPTY;
          m_valid <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/reg_pipe_skid.sv
// Chain of skid stages with valid/ready, flush and occupancy count.
// Count tracks accepted minus delivered entries across all stages.
module reg_pipe_skid
  import reg_pkg::*;
#(
  parameter int REG_DATA_WIDTH  = 32,
  parameter int REG_STAGES      = 1,
  parameter int REG_COUNT_WIDTH = 4
) (
  input  logic                       REG_Clk,
  input  logic                       REG_Reset,
  input  logic                       REG_Flush,
  input  logic                       REG_In_Valid,
  output logic                       REG_In_Ready,
  input  logic [REG_DATA_WIDTH-1:0]  REG_Data_InBUS,
  output logic                       REG_Out_Valid,
  input  logic                       REG_Out_Ready,
  output logic [REG_DATA_WIDTH-1:0]  REG_Data_OutBUS,
  output logic [REG_COUNT_WIDTH-1:0] REG_Count
);

  if (REG_STAGES < 1 || REG_STAGES > REG_STAGES_MAX) begin : g_bad_stages
    $error("reg_pipe_skid: REG_STAGES out of range");
  end

  if (REG_COUNT_WIDTH < min_count_width(REG_STAGES)) begin : g_bad_cw
    $error("reg_pipe_skid: REG_COUNT_WIDTH too narrow");
  end

  localparam logic [REG_COUNT_WIDTH-1:0] CNT_ONE =
    {{(REG_COUNT_WIDTH-1){1'b0}}, 1'b1};

  logic [REG_STAGES:0]                     valid_c;
  logic [REG_STAGES:0]                     ready_c;
  logic [REG_STAGES:0][REG_DATA_WIDTH-1:0] data_c;
  logic [REG_COUNT_WIDTH-1:0]              count_q;
  logic                                    in_fire;
  logic                                    out_fire;

  assign valid_c[0]          = REG_In_Valid;
  assign data_c[0]           = REG_Data_InBUS;
  assign ready_c[REG_STAGES] = REG_Out_Ready;

  assign REG_In_Ready    = ready_c[0];
  assign REG_Out_Valid   = valid_c[REG_STAGES];
  assign REG_Data_OutBUS = data_c[REG_STAGES];
  assign REG_Count       = count_q;

  assign in_fire  = REG_In_Valid & ready_c[0];
  assign out_fire = valid_c[REG_STAGES] & REG_Out_Ready;

  for (genvar k = 0; k < REG_STAGES; k++) begin : g_stage
    reg_skid_stage #(
      .DATA_WIDTH(REG_DATA_WIDTH)
    ) u_stage (
      .clk      (REG_Clk),
      .reset    (REG_Reset),
      .flush    (REG_Flush),
      .in_valid (valid_c[k]),
      .in_ready (ready_c[k]),
      .in_data  (data_c[k]),
      .out_valid(valid_c[k+1]),
      .out_ready(ready_c[k+1]),
      .out_data (data_c[k+1])
    );
  end

  // Occupancy: +1 per accept, -1 per delivery, zero on kill.
  always_ff @(posedge REG_Clk) begin
    if (REG_Reset || REG_Flush) begin
      count_q <= '0;
    end else begin
      unique case ({in_fire, out_fire})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_pipe_skid.sv
// Bench for reg_pipe_skid: queue model over 1/2/4-stage instances
// plus directed literal checks on the 2-stage instance.
module tb_reg_pipe_skid;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] data_in = '0;

  logic        ir   [NI];
  logic        ov   [NI];
  logic [31:0] dout [NI];
  logic [3:0]  cnt  [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    reg_pipe_skid #(
      .REG_DATA_WIDTH (32),
      .REG_STAGES     (g == 0 ? 2 : (g == 1 ? 1 : 4)),
      .REG_COUNT_WIDTH(4)
    ) u_dut (
      .REG_Clk        (clk),
      .REG_Reset      (reset),
      .REG_Flush      (flush),
      .REG_In_Valid   (in_valid),
      .REG_In_Ready   (ir[g]),
      .REG_Data_InBUS (data_in),
      .REG_Out_Valid  (ov[g]),
      .REG_Out_Ready  (out_ready),
      .REG_Data_OutBUS(dout[g]),
      .REG_Count      (cnt[g])
    );
  end

  function automatic int stg(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
  endfunction

  int checks = 0;
  int failures = 0;

  task automatic check(input bit ok, input string n,
                       input longint a, input longint e);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  task automatic lit(input string n, input longint a, input longint e);
    check(a == e, n, a, e);
  endtask

  // Behavioural model: one FIFO per instance, entry count = size.
  logic [31:0] mq [NI][16];
  int hd [NI];
  int tl [NI];
  bit armed = 1'b0;
  bit was_clr = 1'b0;
  bit was_rst = 1'b0;

  always @(negedge clk) begin
    int sz;
    if (armed) begin
      for (int i = 0; i < NI; i++) begin
        sz = tl[i] - hd[i];
        check(int'(cnt[i]) == sz, $sformatf("count[%0d]", i), cnt[i], sz);
        if (ov[i])
          check(sz > 0 && dout[i] == mq[i][hd[i] & 15],
                $sformatf("out_data[%0d]", i), dout[i], mq[i][hd[i] & 15]);
        if (!ir[i])
          check(sz >= 2, $sformatf("ready_low_occ[%0d]", i), sz, 2);
        else
          check(sz < 2 * stg(i), $sformatf("ready_high_occ[%0d]", i),
                sz, 2 * stg(i) - 1);
        if (was_clr) begin
          lit($sformatf("clr_ready[%0d]", i), ir[i], 1);
          lit($sformatf("clr_valid[%0d]", i), ov[i], 0);
        end
        if (was_rst)
          lit($sformatf("rst_data[%0d]", i), dout[i], 0);
      end
    end
    was_clr = reset | flush;
    was_rst = reset;
    for (int i = 0; i < NI; i++) begin
      if (reset || flush) begin
        hd[i] = 0;
        tl[i] = 0;
      end else if (armed) begin
        if (ov[i] && out_ready) hd[i]++;
        if (in_valid && ir[i]) begin
          mq[i][tl[i] & 15] = data_in;
          tl[i]++;
        end
      end
    end
    if (reset) armed = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    bit accept;
    logic [31:0] got [$];

    // Reset held with traffic offered
    reset = 1'b1;
    in_valid = 1'b1;
    data_in = 32'hDEADBEEF;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        reset = 1'b0;
        in_valid = 1'b0;
      end
      step();
      lit("rst_valid", ov[0], 0);
      lit("rst_data", dout[0], 0);
      lit("rst_count", cnt[0], 0);
      lit("rst_ready", ir[0], 1);
    end

    // Streaming 1..10 with Out_Ready high
    out_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      in_valid = (k <= 10);
      data_in = 32'(k);
      step();
      lit("str_valid", ov[0], (k >= 2 && k <= 11) ? 1 : 0);
      if (k >= 2 && k <= 11) lit("str_data", dout[0], k - 1);
      lit("str_count", cnt[0], (k == 1 || k == 11) ? 1 : (k <= 10 ? 2 : 0));
      lit("str_ready", ir[0], 1);
    end

    // Backpressure: A0..A5 offered, Out_Ready low
    in_valid = 1'b0;
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      data_in = 32'hA0 + 32'(acc);
      accept = ir[0];
      step();
      if (accept) acc++;
      lit("bp_ready", ir[0], (c < 3) ? 1 : 0);
    end
    lit("bp_accepted", acc, 4);
    lit("bp_count", cnt[0], 4);
    lit("bp_head", dout[0], 32'hA0);
    out_ready = 1'b1;
    for (int c = 0; c < 30 && got.size() < 6; c++) begin
      in_valid = (acc < 6);
      data_in = 32'hA0 + 32'(acc);
      accept = ir[0] && in_valid;
      if (ov[0]) got.push_back(dout[0]);
      step();
      if (accept) acc++;
    end
    in_valid = 1'b0;
    lit("bp_delivered", got.size(), 6);
    for (int j = 0; j < got.size(); j++)
      lit($sformatf("bp_order[%0d]", j), got[j], 32'hA0 + 32'(j));
    repeat (4) step();

    // Flush mid-stream with count 3
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      data_in = 32'hB1 + 32'(c);
      step();
    end
    lit("fl_pre_count", cnt[0], 3);
    lit("fl_pre_head", dout[0], 32'hB1);
    flush = 1'b1;
    in_valid = 1'b1;
    data_in = 32'h77;
    for (int c = 0; c < 2; c++) begin
      step();
      lit("fl_count", cnt[0], 0);
      lit("fl_valid", ov[0], 0);
      lit("fl_ready", ir[0], 1);
      lit("fl_data_kept", dout[0], 32'hB1);
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      lit("fl_no_output", ov[0], 0);
    end

    // Reset beats flush and an out-fire while full
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      data_in = 32'hC0 + 32'(c);
      step();
    end
    lit("rp_pre_count", cnt[0], 4);
    lit("rp_pre_ready", ir[0], 0);
    reset = 1'b1;
    flush = 1'b1;
    out_ready = 1'b1;
    data_in = 32'h55;
    step();
    lit("rp_valid", ov[0], 0);
    lit("rp_data", dout[0], 0);
    lit("rp_count", cnt[0], 0);
    lit("rp_ready", ir[0], 1);
    reset = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    step();

    // Random handshakes, occasional flush
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      if (c < 1500)
        out_ready = ($urandom_range(0, 1) != 0);
      else
        out_ready = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 63) == 0);
      data_in = $urandom;
      step();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (20) step();
    for (int i = 0; i < NI; i++)
      lit($sformatf("drain_count[%0d]", i), cnt[i], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
